// File: rtl/dsp_pkg.sv
// Shared definitions for the DSP output-side collector: default widths,
// the legal latency range and the pointer-width helper.
package dsp_pkg;

  localparam int PW_DEFAULT = 48;
  localparam int LAT_MIN    = 0;
  localparam int LAT_MAX    = 4;

  // Number of address bits needed to index n entries (n >= 1).
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/sync_fifo_core.sv
// Result storage: power-of-two register FIFO with extended pointers.
// Full/empty come from the pointer MSB compare.
module sync_fifo_core
  import dsp_pkg::*;
#(
  parameter int PW    = PW_DEFAULT,
  parameter int DEPTH = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic [PW-1:0]             wr_data,
  input  logic                      rd_en,
  output logic [PW-1:0]             rd_data,
  output logic                      full,
  output logic [clog2(DEPTH):0]     count
);

  localparam int AW = clog2(DEPTH);

  logic [PW-1:0] mem [DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;

  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (wr_en) begin
        mem[wr_ptr[AW-1:0]] <= wr_data;
        wr_ptr              <= wr_ptr + 1'b1;
      end
      // A read of an empty FIFO is ignored so the pointers never cross.
      if (rd_en && (count != '0)) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/dsp_result_collector.sv
// Tracks accepted operand sets through the DSP latency and captures the
// matching P result; credits reserve a FIFO slot at acceptance time.
module dsp_result_collector
  import dsp_pkg::*;
#(
  parameter int PW    = PW_DEFAULT,
  parameter int LAT   = 2,
  parameter int DEPTH = 4,
  parameter int CW    = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [PW-1:0] dsp_p,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [PW-1:0] out_data,
  output logic [CW-1:0] occupancy,
  output logic          overflow
);

  localparam int AW = clog2(DEPTH);

  // Handshakes: a transfer happens on a cycle where valid & ready are both
  // high at the rising edge; ready never depends on the same-side valid.
  logic          accept;
  logic          pop;
  logic          cap;
  logic          wr_en;
  logic          fifo_full;
  logic [AW:0]   fifo_count;
  logic [CW-1:0] occ_q;
  logic          ovf_q;

  assign in_ready  = (occ_q < CW'(DEPTH));
  assign accept    = in_valid & in_ready;
  assign out_valid = (fifo_count != '0);
  assign pop       = out_valid & out_ready;
  assign occupancy = occ_q;
  assign overflow  = ovf_q;

  generate
    if (LAT == 0) begin : g_lat0
      assign cap = accept;
    end else begin : g_pipe
      logic [LAT-1:0] track_q;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          track_q <= '0;
        end else begin
          track_q[0] <= accept;
          for (int i = 1; i < LAT; i++) track_q[i] <= track_q[i-1];
        end
      end
      assign cap = track_q[LAT-1];
    end
  endgenerate

  // A full FIFO can still take a capture when the head leaves this cycle.
  assign wr_en = cap & (~fifo_full | pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      occ_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      occ_q <= occ_q + CW'(accept) - CW'(pop);
      if (cap && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  sync_fifo_core #(
    .PW    (PW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (dsp_p),
    .rd_en   (pop),
    .rd_data (out_data),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule
